// File: rtl/bp_cce_lce_req_rx.sv
// ---------------------------------------------------------------------------
// bp_cce_lce_req_rx
//
// Receive side of the CCE for LCE requests. Incoming BedRock LCE request
// messages are filtered (destination must be this CCE, type must be one of
// rd / wr / uc_rd / uc_wr), decoded into a compact request record and queued
// in a small FIFO. The consumer sees the head record on the req_* outputs and
// pops it with req_yumi_i. Filtered-out messages pulse drop_o; enqueued ones
// bump accept_count_o.
//
// Ports
//   clk_i            clock, all state on rising edge
//   reset_n_i        synchronous active-low reset
//   cce_id_i         this CCE's id
//   lce_req_i        packed bp_lce_req_msg_s (header, payload, data)
//   lce_req_v_i      message valid
//   lce_req_ready_o  message can be accepted this cycle
//   req_v_o          head record valid
//   req_yumi_i       consumer pops the head record
//   req_type_o       0=rd 1=wr 2=uc_rd 3=uc_wr
//   req_addr_o       request address
//   req_size_o       BedRock message size
//   req_src_lce_o    requesting LCE
//   req_lru_way_o    LRU way from payload
//   req_non_excl_o   non-exclusive read (rd only)
//   req_data_o       store data (uc_wr only, zero otherwise)
//   drop_o           one-cycle pulse after a message was accepted and dropped
//   accept_count_o   count of enqueued messages, wraps at 16 bits
// ---------------------------------------------------------------------------

package bp_cce_lce_req_rx_pkg;

   typedef enum int {
      e_bp_default_cfg = 0
   } bp_params_e;

   typedef struct packed {
      int paddr_width;
      int lce_id_width;
      int cce_id_width;
      int lce_assoc;
      int dword_width;
      int cce_block_width;
   } bp_proc_param_s;

   localparam bp_proc_param_s bp_default_cfg_gp = '{
      paddr_width     : 40,
      lce_id_width    : 4,
      cce_id_width    : 4,
      lce_assoc       : 8,
      dword_width     : 64,
      cce_block_width : 512
   };

   function automatic bp_proc_param_s bp_proc_param(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: return bp_default_cfg_gp;
         default:          return bp_default_cfg_gp;
      endcase
   endfunction

   localparam int paddr_width_gp     = bp_default_cfg_gp.paddr_width;
   localparam int lce_id_width_gp    = bp_default_cfg_gp.lce_id_width;
   localparam int cce_id_width_gp    = bp_default_cfg_gp.cce_id_width;
   localparam int lru_width_gp       = $clog2(bp_default_cfg_gp.lce_assoc);
   localparam int dword_width_gp     = bp_default_cfg_gp.dword_width;
   localparam int cce_block_width_gp = bp_default_cfg_gp.cce_block_width;

   // BedRock request message types; any other encoding is dropped.
   localparam logic [3:0] e_bedrock_req_rd    = 4'd0;
   localparam logic [3:0] e_bedrock_req_wr    = 4'd1;
   localparam logic [3:0] e_bedrock_req_uc_rd = 4'd2;
   localparam logic [3:0] e_bedrock_req_uc_wr = 4'd3;

   typedef struct packed {
      logic [3:0]                msg_type;
      logic [2:0]                size;
      logic [paddr_width_gp-1:0] addr;
   } bp_lce_req_header_s;

   typedef struct packed {
      logic [cce_id_width_gp-1:0] dst_id;
      logic [lce_id_width_gp-1:0] src_id;
      logic [lru_width_gp-1:0]    lru_way_id;
      logic                       non_exclusive;
   } bp_lce_req_payload_s;

   typedef struct packed {
      bp_lce_req_header_s            header;
      bp_lce_req_payload_s           payload;
      logic [cce_block_width_gp-1:0] data;
   } bp_lce_req_msg_s;

   // Decoded record held in the request buffer.
   typedef struct packed {
      logic [1:0]                 req_type;
      logic [paddr_width_gp-1:0]  addr;
      logic [2:0]                 size;
      logic [lce_id_width_gp-1:0] src_lce;
      logic [lru_width_gp-1:0]    lru_way;
      logic                       non_excl;
      logic [dword_width_gp-1:0]  data;
   } req_entry_s;

endpackage

module bp_cce_lce_req_rx
   import bp_cce_lce_req_rx_pkg::*;
#(
   parameter bp_params_e     bp_params_p          = e_bp_default_cfg,
   parameter int             els_p                = 2,
   localparam bp_proc_param_s cfg_lp              = bp_proc_param(bp_params_p),
   localparam int            paddr_width_p        = cfg_lp.paddr_width,
   localparam int            lce_id_width_p       = cfg_lp.lce_id_width,
   localparam int            cce_id_width_p       = cfg_lp.cce_id_width,
   localparam int            lru_width_p          = $clog2(cfg_lp.lce_assoc),
   localparam int            dword_width_p        = cfg_lp.dword_width,
   localparam int            lce_req_msg_width_lp = $bits(bp_lce_req_msg_s)
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic [cce_id_width_p-1:0]       cce_id_i,
   input  logic [lce_req_msg_width_lp-1:0] lce_req_i,
   input  logic                            lce_req_v_i,
   output logic                            lce_req_ready_o,
   output logic                            req_v_o,
   input  logic                            req_yumi_i,
   output logic [1:0]                      req_type_o,
   output logic [paddr_width_p-1:0]        req_addr_o,
   output logic [2:0]                      req_size_o,
   output logic [lce_id_width_p-1:0]       req_src_lce_o,
   output logic [lru_width_p-1:0]          req_lru_way_o,
   output logic                            req_non_excl_o,
   output logic [dword_width_p-1:0]        req_data_o,
   output logic                            drop_o,
   output logic [15:0]                     accept_count_o
);

   localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_width_lp = $clog2(els_p + 1);

   typedef enum logic {
      e_reset,
      e_ready
   } state_e;

   state_e                  state_r, state_n;
   logic [ptr_width_lp-1:0] head_r, tail_r;
   logic [cnt_width_lp-1:0] count_r;
   req_entry_s              mem_r [els_p];
   logic                    drop_r;
   logic [15:0]             accept_count_r;

   bp_lce_req_msg_s msg;
   req_entry_s      entry_n;
   req_entry_s      head_entry;
   logic            type_ok, dst_ok, full, accept, enq, deq;

   assign msg = bp_lce_req_msg_s'(lce_req_i);

   // Only the low dword of the data block is ever carried forward.
   logic unused_data;
   assign unused_data = ^msg.data[cce_block_width_gp-1:dword_width_p];

   // ---------------- handshake ----------------
   assign full    = (count_r == cnt_width_lp'(els_p));
   assign type_ok = msg.header.msg_type inside {e_bedrock_req_rd, e_bedrock_req_wr,
                                                e_bedrock_req_uc_rd, e_bedrock_req_uc_wr};
   assign dst_ok  = (msg.payload.dst_id == cce_id_i);

   // Ready is a function of state and occupancy only; a pop in the same
   // cycle does not open a slot until the next cycle.
   assign lce_req_ready_o = reset_n_i & (state_r == e_ready) & ~full;
   assign accept          = lce_req_v_i & lce_req_ready_o;
   assign enq             = accept & type_ok & dst_ok;

   assign req_v_o = reset_n_i & (count_r != '0);
   // A pop with nothing buffered is illegal and simply ignored.
   assign deq     = req_yumi_i & req_v_o;

   // ---------------- decode ----------------
   // NOTE: every signal driven in an always_comb gets a default on the first
   // line so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      entry_n          = '0;
      entry_n.addr     = msg.header.addr;
      entry_n.size     = msg.header.size;
      entry_n.src_lce  = msg.payload.src_id;
      entry_n.lru_way  = msg.payload.lru_way_id;
      entry_n.req_type = msg.header.msg_type[1:0];
      case (msg.header.msg_type)
         e_bedrock_req_rd:    entry_n.non_excl = msg.payload.non_exclusive;
         e_bedrock_req_uc_wr: entry_n.data     = msg.data[dword_width_p-1:0];
         default: ;
      endcase
   end

   // ---------------- control FSM ----------------
   always_comb begin
      state_n = state_r;
      case (state_r)
         e_reset: state_n = e_ready;
         e_ready: state_n = e_ready;
         default: state_n = e_reset;
      endcase
   end

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r        <= e_reset;
         head_r         <= '0;
         tail_r         <= '0;
         count_r        <= '0;
         drop_r         <= 1'b0;
         accept_count_r <= '0;
      end else begin
         state_r <= state_n;
         drop_r  <= accept & ~(type_ok & dst_ok);
         if (enq) begin
            tail_r         <= tail_r + ptr_width_lp'(1);
            accept_count_r <= accept_count_r + 16'd1;
         end
         if (deq) begin
            head_r <= head_r + ptr_width_lp'(1);
         end
         count_r <= count_r + cnt_width_lp'(enq) - cnt_width_lp'(deq);
      end
   end

   // NOTE: the buffer storage is deliberately not reset; count_r gates
   // req_v_o, so stale entries are never observed as valid.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_r[tail_r] <= entry_n;
      end
   end

   // ---------------- outputs ----------------
   assign head_entry     = mem_r[head_r];
   assign req_type_o     = head_entry.req_type;
   assign req_addr_o     = head_entry.addr;
   assign req_size_o     = head_entry.size;
   assign req_src_lce_o  = head_entry.src_lce;
   assign req_lru_way_o  = head_entry.lru_way;
   assign req_non_excl_o = head_entry.non_excl;
   assign req_data_o     = head_entry.data;
   assign drop_o         = reset_n_i & drop_r;
   assign accept_count_o = accept_count_r;

endmodule

// File: doc/bp_cce_lce_req_rx.md
BP_CCE_LCE_REQ_RX -- requirements
Module: bp_cce_lce_req_rx

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  bp_params_p, e_bp_default_cfg, processor config supplying paddr_width_p, lce_id_width_p, cce_id_width_p, lce_assoc_p, dword_width_p, cce_block_width_p
  els_p, 2, request buffer depth, power of two, >= 2
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk_i  in  1  sole clock, all state on rising edge
  reset_n_i  in  1  synchronous, active-low reset
  cce_id_i  in  cce_id_width_p  this CCE's id
  lce_req_i  in  lce_req_msg_width_lp  BedRock LCE request message (header, payload, data)
  lce_req_v_i  in  1  message valid
  lce_req_ready_o  out  1  able to accept this cycle (ready->valid)
  req_v_o  out  1  decoded request at buffer head valid
  req_yumi_i  in  1  consumer takes head; only legal when req_v_o=1
  req_type_o  out  2  0=rd, 1=wr, 2=uc_rd, 3=uc_wr
  req_addr_o  out  paddr_width_p  request address
  req_size_o  out  3  BedRock msg size
  req_src_lce_o  out  lce_id_width_p  requesting LCE
  req_lru_way_o  out  lg(lce_assoc_p)  LRU way from payload
  req_non_excl_o  out  1  non-exclusive read request
  req_data_o  out  dword_width_p  store data; zero unless uc_wr
  drop_o  out  1  one-cycle pulse: message was dropped
  accept_count_o  out  16  accepted-message counter
REQ-003 Clock is clk_i only; reset_n_i is synchronous and active-low. No other clock or reset.

Function
REQ-004 FSM states: e_reset, e_ready. Reset forces e_reset; e_reset moves to e_ready on the next cycle with reset_n_i=1; e_ready holds until reset.
REQ-005 lce_req_ready_o SHALL be 1 only in e_ready with buffer occupancy < els_p. It SHALL NOT depend on req_yumi_i (no full-buffer pass-through).
REQ-006 The block accepts a message when lce_req_v_i & lce_req_ready_o. If lce_req_v_i is 1 while ready is 0, the message is ignored and nothing changes.
REQ-007 An accepted message is dropped (not enqueued) if payload dst_id != cce_id_i or msg_type is not rd, wr, uc_rd or uc_wr. drop_o pulses in the cycle after acceptance. accept_count_o does not change on a drop.
REQ-008 A valid accepted message SHALL be decoded and enqueued at the tail, and accept_count_o SHALL increment by 1 in the following cycle, wrapping from 0xFFFF to 0.
REQ-009 Decode rules:
  - addr, size, src_id, lru_way_id and non_exclusive are taken from the header/payload.
  - req_non_excl_o is forced to 0 for types other than rd.
  - req_data_o = data[dword_width_p-1:0] for uc_wr, otherwise 0.
REQ-010 Latency: a message accepted at cycle N drives req_v_o=1 at N+1 at the earliest. There is no combinational path from lce_req_i to the req_* outputs.
REQ-011 req_v_o=1 iff occupancy>0. req_* outputs reflect the head entry and SHALL stay stable while req_v_o=1 and req_yumi_i=0.
REQ-012 req_yumi_i dequeues the head at the clock edge. Enqueue and dequeue in the same cycle leave occupancy unchanged. Head and tail pointers wrap modulo els_p. FIFO order is preserved.
REQ-013 When full, lce_req_ready_o=0. A yumi in that cycle makes ready=1 in the next cycle.
REQ-014 req_yumi_i while req_v_o=0 is illegal. The block SHALL ignore it, with no pointer change.

Reset
REQ-015 While reset_n_i=0:
  - occupancy=0 and both pointers=0
  - state=e_reset
  - accept_count_o=0
  - drop_o=0, req_v_o=0, lce_req_ready_o=0
REQ-016 Reset asserted mid-operation discards all buffered entries at that edge. No partially accepted message survives.
REQ-017 In the first cycle after reset release (e_reset), lce_req_ready_o=0. Ready rises the cycle after that.

Verification
REQ-018 Reset release, then one rd (addr 0x8000_0040, src 1, lru_way 3, dst=cce_id_i) -> req_v_o=1 next cycle; type=0, addr=0x8000_0040, lru=3; accept_count_o=1.
REQ-019 uc_wr with data 0xDEAD_BEEF_0123_4567, then yumi -> req_data_o=0xDEAD_BEEF_0123_4567, type=3; req_v_o=0 after yumi.
REQ-020 els_p=2, three back-to-back valids with no yumi -> first two accepted, ready=0 on the third; one yumi -> ready=1 next cycle; order preserved.
REQ-021 Message with dst_id != cce_id_i -> drop_o pulses one cycle, req_v_o stays 0, accept_count_o unchanged.
REQ-022 Buffer full with simultaneous yumi and valid (ready=0) -> only the dequeue occurs; occupancy goes 2->1.
REQ-023 Two entries buffered, reset_n_i=0 for one cycle -> req_v_o=0 and accept_count_o=0; ready low for one cycle after release, then high.
